// File: rtl/lif_post_neuron.sv
`default_nettype none
// ============================================================================
// Module      : lif_post_neuron
// Description : Leaky integrate-and-fire post-synaptic neuron. Sums the
//               weights of the presynaptic inputs spiking this cycle, applies
//               a shift-based leak, fires a one-cycle pulse on reaching the
//               threshold and then sits out a refractory period.
// Revision    : 1.0 - initial release
// ============================================================================
module lif_post_neuron #(
  parameter int N_PRE      = 4,
  parameter int W_W        = 4,
  parameter int V_W        = 8,
  parameter int THRESHOLD  = 32,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRACT    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [N_PRE-1:0]     pre_spike,
  input  logic [N_PRE*W_W-1:0] weight,
  output logic                 post_spike,
  output logic [V_W-1:0]       v_mem,
  output logic [1:0]           state,
  output logic [7:0]           spike_count
);

  // State encoding is visible on the state port, so it is fixed here.
  localparam logic [1:0] c_st_integ  = 2'b00;
  localparam logic [1:0] c_st_fire   = 2'b01;
  localparam logic [1:0] c_st_refrac = 2'b10;

  // Two guard bits above the membrane width absorb leak-then-add headroom.
  localparam int c_sum_w = V_W + 2;
  localparam int c_ref_w = (REFRACT > 2) ? $clog2(REFRACT) : 1;

  localparam logic [c_ref_w-1:0] c_ref_load = (REFRACT > 0) ? c_ref_w'(REFRACT - 1) : '0;
  localparam logic [c_sum_w-1:0] c_v_max    = c_sum_w'({V_W{1'b1}});
  localparam logic [c_sum_w-1:0] c_thresh   = c_sum_w'(THRESHOLD);

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [V_W-1:0]     r_v_mem;
  logic [V_W-1:0]     w_v_nxt;
  logic               r_post;
  logic               w_post_nxt;
  logic [c_ref_w-1:0] r_ref_cnt;
  logic [c_ref_w-1:0] w_ref_nxt;
  logic [7:0]         r_cnt;
  logic [7:0]         w_cnt_nxt;

  logic [c_sum_w-1:0] w_lane [N_PRE];
  logic [c_sum_w-1:0] w_sum;
  logic [c_sum_w-1:0] w_leak;
  logic [c_sum_w-1:0] w_v_raw;
  logic [c_sum_w-1:0] w_v_sat;
  logic               w_fire;

  // Per-lane gated weight: contributes only when that input spikes.
  for (genvar gi = 0; gi < N_PRE; gi++) begin : g_lane
    assign w_lane[gi] = pre_spike[gi] ? c_sum_w'(weight[gi*W_W +: W_W]) : '0;
  end

  // Adder tree over all lanes.
  always_comb begin
    w_sum = '0;
    for (int i = 0; i < N_PRE; i++) begin
      w_sum = w_sum + w_lane[i];
    end
  end

  // Leak never exceeds the potential, so the subtraction cannot wrap.
  assign w_leak  = c_sum_w'(r_v_mem >> LEAK_SHIFT);
  assign w_v_raw = c_sum_w'(r_v_mem) - w_leak + w_sum;
  assign w_v_sat = (w_v_raw > c_v_max) ? c_v_max : w_v_raw;
  assign w_fire  = (w_v_sat >= c_thresh);

  // State register; en low freezes the FSM, reset wins over en.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_integ;
    end else if (en) begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; the unused code 11 behaves as INTEG.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_fire:   w_state_nxt = (REFRACT > 0) ? c_st_refrac : c_st_integ;
      c_st_refrac: w_state_nxt = (r_ref_cnt == '0) ? c_st_integ : c_st_refrac;
      default:     w_state_nxt = w_fire ? c_st_fire : c_st_integ;
    endcase
  end

  // Datapath next values; inputs only matter while integrating.
  always_comb begin
    w_v_nxt    = r_v_mem;
    w_post_nxt = 1'b0;
    w_ref_nxt  = r_ref_cnt;
    w_cnt_nxt  = r_cnt;
    case (r_state)
      c_st_fire: begin
        w_v_nxt   = '0;
        w_ref_nxt = c_ref_load;
      end
      c_st_refrac: begin
        w_v_nxt = '0;
        if (r_ref_cnt != '0) begin
          w_ref_nxt = r_ref_cnt - 1'b1;
        end
      end
      default: begin
        if (w_fire) begin
          w_v_nxt    = '0;
          w_post_nxt = 1'b1;
          w_cnt_nxt  = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
        end else begin
          w_v_nxt = w_v_sat[V_W-1:0];
        end
      end
    endcase
  end

  // Datapath registers; a disabled cycle still retires any pending pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_v_mem   <= '0;
      r_post    <= 1'b0;
      r_ref_cnt <= '0;
      r_cnt     <= '0;
    end else if (en) begin
      r_v_mem   <= w_v_nxt;
      r_post    <= w_post_nxt;
      r_ref_cnt <= w_ref_nxt;
      r_cnt     <= w_cnt_nxt;
    end else begin
      r_post    <= 1'b0;
    end
  end

  assign post_spike  = r_post;
  assign v_mem       = r_v_mem;
  assign state       = r_state;
  assign spike_count = r_cnt;

endmodule
`default_nettype wire
